if_stage: RTL and testbench

IF_STAGE -- requirements
Module: if_stage

---
 rtl/if_stage_pkg.sv | 18 +
 rtl/if_stage_npc.sv | 46 ++++
 rtl/if_stage.sv | 88 ++++++++
 tb/tb_if_stage.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/if_stage_pkg.sv
// Shared constants and helpers for the instruction-fetch stage.
// Holds the reset/exception vectors, the legal IM window and the fetch-fault check.
package if_stage_pkg;

    localparam logic [31:0] PC_RESET  = 32'h0000_3000;
    localparam logic [31:0] EXC_ENTRY = 32'h0000_4180;
    localparam logic [31:0] IM_LO     = 32'h0000_3000;
    localparam logic [31:0] IM_HI     = 32'h0000_6FFC;
    localparam logic [4:0]  EXC_ADEL  = 5'd4;
    localparam logic [4:0]  EXC_NONE  = 5'd0;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    // A fetch faults when it is misaligned or falls outside the instruction memory window.
    function automatic logic fetch_fault(input logic [31:0] pc);
        return (pc[1:0] != 2'b00) || (pc < IM_LO) || (pc > IM_HI);
    endfunction

endpackage

// File: rtl/if_stage_npc.sv
// Combinational next-PC selection for the fetch stage.
// Exceptions and eret win over stall; control transfers resolve against the PC held in D.
module if_stage_npc
    import if_stage_pkg::*;
(
    input  logic        req,
    input  logic        eret,
    input  logic        stall,
    input  logic        branch_D,
    input  logic        jump_D,
    input  logic        jr_D,
    input  logic [15:0] imm16_D,
    input  logic [25:0] index26_D,
    input  logic [31:0] jr_target_D,
    input  logic [31:0] epc,
    input  logic [31:0] pc_f,
    input  logic [31:0] pc_d,
    output logic [31:0] npc
);

    logic [31:0] branch_offset;
    logic [31:0] branch_target;
    logic [31:0] jump_target;

    assign branch_offset = {{14{imm16_D[15]}}, imm16_D, 2'b00};
    assign branch_target = pc_d + 32'd4 + branch_offset;
    assign jump_target   = {pc_d[31:28], index26_D, 2'b00};

    always_comb begin
        npc = pc_f + 32'd4;
        if (req) begin
            npc = EXC_ENTRY;
        end else if (eret) begin
            npc = epc;
        end else if (stall) begin
            npc = pc_f;
        end else if (branch_D) begin
            npc = branch_target;
        end else if (jump_D) begin
            npc = jump_target;
        end else if (jr_D) begin
            npc = jr_target_D;
        end
    end

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC register, next-PC mux instance and the IF/ID pipeline register.
// im_addr comes straight from the PC register so instruction memory sees no input-to-output path.
module if_stage
    import if_stage_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        branch_D,
    input  logic        jump_D,
    input  logic        jr_D,
    input  logic        cti_D,
    input  logic [15:0] imm16_D,
    input  logic [25:0] index26_D,
    input  logic [31:0] jr_target_D,
    input  logic        req,
    input  logic        eret,
    input  logic [31:0] epc,
    output logic [31:0] im_addr,
    input  logic [31:0] im_rdata,
    output logic [31:0] instr_D,
    output logic [31:0] pc_D,
    output logic        bd_D,
    output logic [4:0]  exccode_D
);

    logic [31:0] pc_f;
    logic [31:0] npc;
    logic        fault_f;

    if_stage_npc u_npc (
        .req         (req),
        .eret        (eret),
        .stall       (stall),
        .branch_D    (branch_D),
        .jump_D      (jump_D),
        .jr_D        (jr_D),
        .imm16_D     (imm16_D),
        .index26_D   (index26_D),
        .jr_target_D (jr_target_D),
        .epc         (epc),
        .pc_f        (pc_f),
        .pc_d        (pc_D),
        .npc         (npc)
    );

    assign im_addr = pc_f;
    assign fault_f = fetch_fault(pc_f);

    always_ff @(posedge clk) begin
        if (!reset) begin
            pc_f <= PC_RESET;
        end else begin
            pc_f <= npc;
        end
    end

    // Flushes beat stall; on a faulting fetch a NOP carrying AdEL enters D in place of IM data.
    always_ff @(posedge clk) begin
        if (!reset) begin
            instr_D   <= NOP_INSTR;
            pc_D      <= PC_RESET;
            bd_D      <= 1'b0;
            exccode_D <= EXC_NONE;
        end else if (req) begin
            instr_D   <= NOP_INSTR;
            pc_D      <= EXC_ENTRY;
            bd_D      <= 1'b0;
            exccode_D <= EXC_NONE;
        end else if (eret) begin
            instr_D   <= NOP_INSTR;
            pc_D      <= epc;
            bd_D      <= 1'b0;
            exccode_D <= EXC_NONE;
        end else if (!stall) begin
            pc_D <= pc_f;
            bd_D <= cti_D;
            if (fault_f) begin
                instr_D   <= NOP_INSTR;
                exccode_D <= EXC_ADEL;
            end else begin
                instr_D   <= im_rdata;
                exccode_D <= EXC_NONE;
            end
        end
    end

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: directed scenarios followed by randomized traffic,
// all compared cycle by cycle against a behavioural model of the fetch stage.
module tb_if_stage;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        branch_D;
    logic        jump_D;
    logic        jr_D;
    logic        cti_D;
    logic [15:0] imm16_D;
    logic [25:0] index26_D;
    logic [31:0] jr_target_D;
    logic        req;
    logic        eret;
    logic [31:0] epc;
    logic [31:0] im_addr;
    logic [31:0] im_rdata;
    logic [31:0] instr_D;
    logic [31:0] pc_D;
    logic        bd_D;
    logic [4:0]  exccode_D;

    int check_count = 0;
    int pass_count  = 0;

    logic [31:0] m_pc;
    logic [31:0] m_instr;
    logic [31:0] m_pcd;
    logic        m_bd;
    logic [4:0]  m_exc;

    if_stage dut (
        .clk         (clk),
        .reset       (reset),
        .stall       (stall),
        .branch_D    (branch_D),
        .jump_D      (jump_D),
        .jr_D        (jr_D),
        .cti_D       (cti_D),
        .imm16_D     (imm16_D),
        .index26_D   (index26_D),
        .jr_target_D (jr_target_D),
        .req         (req),
        .eret        (eret),
        .epc         (epc),
        .im_addr     (im_addr),
        .im_rdata    (im_rdata),
        .instr_D     (instr_D),
        .pc_D        (pc_D),
        .bd_D        (bd_D),
        .exccode_D   (exccode_D)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction memory contents are a fixed scramble of the address so every word is distinct.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0] ^ 16'hBEEF, a[31:16] ^ 16'h1234};
    endfunction

    assign im_rdata = mem_word(im_addr);

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        check_count++;
        if (observed === expected) begin
            pass_count++;
        end else begin
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", tag, observed, expected, $time);
        end
    endtask

    // One clock of stimulus: drive inputs, advance the model by the architectural rules, compare.
    task automatic applyStimulus(input logic rst_n, input logic rq, input logic er, input logic st,
                                 input logic br, input logic jp, input logic jrr, input logic cti,
                                 input logic [15:0] imm, input logic [25:0] idx,
                                 input logic [31:0] tgt, input logic [31:0] epc_v);
        logic [31:0] next_pc;
        logic        fault;
        int          offset;
        reset = rst_n; req = rq; eret = er; stall = st;
        branch_D = br; jump_D = jp; jr_D = jrr; cti_D = cti;
        imm16_D = imm; index26_D = idx; jr_target_D = tgt; epc = epc_v;
        @(posedge clk);
        if (!rst_n) begin
            m_pc = 32'h3000; m_instr = 0; m_pcd = 32'h3000; m_bd = 0; m_exc = 0;
        end else begin
            offset = 4 * int'($signed(imm));
            if (rq)       next_pc = 32'h4180;
            else if (er)  next_pc = epc_v;
            else if (st)  next_pc = m_pc;
            else if (br)  next_pc = m_pcd + 32'd4 + 32'(offset);
            else if (jp)  next_pc = (m_pcd & 32'hF000_0000) | (32'(idx) * 32'd4);
            else if (jrr) next_pc = tgt;
            else          next_pc = m_pc + 32'd4;
            fault = (m_pc % 4 != 0) || (m_pc < 32'h3000) || (m_pc > 32'h6FFC);
            if (rq) begin
                m_instr = 0; m_exc = 0; m_bd = 0; m_pcd = 32'h4180;
            end else if (er) begin
                m_instr = 0; m_exc = 0; m_bd = 0; m_pcd = epc_v;
            end else if (!st) begin
                m_pcd   = m_pc;
                m_bd    = cti;
                m_instr = fault ? 32'h0 : mem_word(m_pc);
                m_exc   = fault ? 5'd4 : 5'd0;
            end
            m_pc = next_pc;
        end
        #1;
        checkOutput("im_addr", im_addr, m_pc);
        checkOutput("instr_D", instr_D, m_instr);
        checkOutput("pc_D", pc_D, m_pcd);
        checkOutput("bd_D", {31'd0, bd_D}, {31'd0, m_bd});
        checkOutput("exccode_D", {27'd0, exccode_D}, {27'd0, m_exc});
    endtask

    task automatic idleCycle();
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 16'h0, 26'h0, 32'h0, 32'h0);
    endtask

    task automatic resetCycles(input int n);
        for (int i = 0; i < n; i++)
            applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 16'h0, 26'h0, 32'h0, 32'h0);
    endtask

    initial begin
        #50000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic r_rq, r_er, r_st, r_br, r_jp, r_jr, r_cti, r_rst;
        logic [15:0] r_imm;
        logic [25:0] r_idx;
        logic [31:0] r_tgt, r_epc;

        // Sequential fetch out of reset, pc_D one step behind.
        resetCycles(2);
        checkOutput("reset_pc", im_addr, 32'h3000);
        checkOutput("reset_pcD", pc_D, 32'h3000);
        idleCycle();
        checkOutput("seq_pc1", im_addr, 32'h3004);
        checkOutput("seq_pcD1", pc_D, 32'h3000);
        checkOutput("seq_exc1", {27'd0, exccode_D}, 32'd0);
        idleCycle();
        checkOutput("seq_pc2", im_addr, 32'h3008);

        // Backward branch from pc_D=0x3010; delay slot 0x3014 enters D flagged.
        resetCycles(1);
        repeat (5) idleCycle();
        checkOutput("br_pre_pcD", pc_D, 32'h3010);
        applyStimulus(1, 0, 0, 0, 1, 0, 0, 1, 16'hFFFC, 26'h0, 32'h0, 32'h0);
        checkOutput("br_target", im_addr, 32'h3004);
        checkOutput("br_slot_pc", pc_D, 32'h3014);
        checkOutput("br_slot_bd", {31'd0, bd_D}, 32'd1);

        // Jump from pc_D=0x3020, then jr to a misaligned target raising AdEL.
        resetCycles(1);
        repeat (9) idleCycle();
        checkOutput("jmp_pre_pcD", pc_D, 32'h3020);
        applyStimulus(1, 0, 0, 0, 0, 1, 0, 1, 16'h0, 26'h0000C40, 32'h0, 32'h0);
        checkOutput("jmp_target", im_addr, 32'h3100);
        applyStimulus(1, 0, 0, 0, 0, 0, 1, 1, 16'h0, 26'h0, 32'h3002, 32'h0);
        checkOutput("jr_target", im_addr, 32'h3002);
        idleCycle();
        checkOutput("adel_exc", {27'd0, exccode_D}, 32'd4);
        checkOutput("adel_instr", instr_D, 32'h0);

        // Branch held off by three stall cycles, redirect on the first free cycle.
        resetCycles(1);
        repeat (3) idleCycle();
        repeat (3) applyStimulus(1, 0, 0, 1, 1, 0, 0, 1, 16'h0010, 26'h0, 32'h0, 32'h0);
        checkOutput("stall_pc", im_addr, 32'h300C);
        checkOutput("stall_pcD", pc_D, 32'h3008);
        applyStimulus(1, 0, 0, 0, 1, 0, 0, 1, 16'h0010, 26'h0, 32'h0, 32'h0);
        checkOutput("stall_redirect", im_addr, 32'h304C);

        // Exception request beats stall, then eret returns to EPC.
        applyStimulus(1, 1, 0, 1, 0, 0, 0, 0, 16'h0, 26'h0, 32'h0, 32'h0);
        checkOutput("req_pc", im_addr, 32'h4180);
        checkOutput("req_pcD", pc_D, 32'h4180);
        checkOutput("req_instr", instr_D, 32'h0);
        applyStimulus(1, 0, 1, 0, 0, 0, 0, 0, 16'h0, 26'h0, 32'h0, 32'h3040);
        checkOutput("eret_pc", im_addr, 32'h3040);
        checkOutput("eret_pcD", pc_D, 32'h3040);

        // Reset dominates a simultaneous request.
        applyStimulus(0, 1, 1, 1, 0, 0, 0, 0, 16'h0, 26'h0, 32'h0, 32'h5000);
        checkOutput("rst_req_pc", im_addr, 32'h3000);
        checkOutput("rst_req_pcD", pc_D, 32'h3000);

        // Randomized traffic.
        for (int i = 0; i < 600; i++) begin
            r_rst = ($urandom_range(0, 99) >= 2);
            r_rq  = ($urandom_range(0, 99) < 4);
            r_er  = ($urandom_range(0, 99) < 4);
            r_st  = ($urandom_range(0, 99) < 20);
            r_br  = ($urandom_range(0, 99) < 12);
            r_jp  = ($urandom_range(0, 99) < 6);
            r_jr  = ($urandom_range(0, 99) < 6);
            r_cti = r_br | r_jp | r_jr | ($urandom_range(0, 7) == 0);
            r_imm = 16'($urandom_range(0, 63)) - 16'd32;
            r_idx = 26'($urandom_range(32'h3000, 32'h6FFC) >> 2);
            r_tgt = $urandom_range(32'h2FF0, 32'h700C);
            r_epc = ($urandom_range(0, 3) == 0) ? $urandom_range(32'h2FF0, 32'h700C)
                                                : ($urandom_range(32'h3000, 32'h6FFC) & 32'hFFFF_FFFC);
            applyStimulus(r_rst, r_rq, r_er, r_st, r_br, r_jp, r_jr, r_cti,
                          r_imm, r_idx, r_tgt, r_epc);
        end

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
